hdb3_decoder: RTL and testbench

Receive-side HDB3 decoder. It takes one ternary line symbol per clock, recognises violation pulses (V) by their polarity, and strips the substituted 000V / B00V groups back to four zeros. It emits NRZ data with a fixed 4-cycle latency. It also flags line-code errors and counts them, and sits after the line-interface slicer as the receive-path counterpart of the encoder chain.

---
 rtl/hdb3_decoder.sv | 107 ++++++++++
 tb/tb_hdb3_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdb3_decoder.sv
// hdb3_decoder: receive-side HDB3 line decoder.
// Takes one ternary symbol per clock. Violations (V) are recognised by their
// polarity, and each 000V / B00V group is restored to four zeros. NRZ data
// appears at s3 of a 4-deep pipeline, so a V can still clear the B pulse and
// the zeros ahead of it before they leave the pipeline. Line-code errors are
// flagged as registered one-cycle pulses and counted in a saturating counter.
module hdb3_decoder #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       hdb3_in,
  input  logic             err_clr,
  output logic             data_out,
  output logic             data_valid,
  output logic             code_err,
  output logic             v_err,
  output logic             zero_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ILL  = 2'b10;

  logic [3:0] sr;          // sr[0] = s0 (newest) .. sr[3] = s3 (oldest)
  logic [1:0] mk_hist;     // raw mark flags of the previous two symbols
  logic       have_mark;
  logic       last_pol;    // 1 = negative
  logic       have_v;
  logic       last_v_pol;
  logic [2:0] zrun;
  logic [2:0] fill;

  logic is_zero, is_ill, is_mark, pol, is_v, any_err;

  // Classify the incoming symbol. Bit 0 marks a pulse and bit 1 gives its sign.
  always_comb begin
    is_zero = (hdb3_in == SYM_ZERO);
    is_ill  = (hdb3_in == SYM_ILL);
    is_mark = hdb3_in[0];
    pol     = hdb3_in[1];
    is_v    = is_mark & have_mark & (pol == last_pol);
    any_err = code_err | v_err | zero_err;
  end

  // Data pipeline. A V clears the whole register. The entries shifting into
  // s1..s3 are the three symbols before the V, so a B pulse is removed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      mk_hist <= '0;
      fill    <= '0;
    end else begin
      sr      <= is_v ? 4'b0000 : {sr[2:0], is_mark};
      mk_hist <= {mk_hist[0], is_mark};
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  // Polarity history and zero-run tracking. Illegal symbols leave both unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_mark  <= 1'b0;
      last_pol   <= 1'b0;
      have_v     <= 1'b0;
      last_v_pol <= 1'b0;
      zrun       <= '0;
    end else if (is_mark) begin
      have_mark <= 1'b1;
      last_pol  <= pol;
      zrun      <= '0;
      if (is_v) begin
        have_v     <= 1'b1;
        last_v_pol <= pol;
      end
    end else if (is_zero && zrun != 3'd7) begin
      zrun <= zrun + 3'd1;
    end
  end

  // Registered error pulses for the symbol just sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_err <= 1'b0;
      v_err    <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      code_err <= is_ill;
      zero_err <= is_zero & (zrun == 3'd3);
      v_err    <= is_v & ((|mk_hist) | (have_v & (pol == last_v_pol)));
    end
  end

  // Saturating error counter. Clear takes priority over a pending error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= '0;
    else if (any_err && err_cnt != {ERR_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end

  assign data_out   = sr[3];
  assign data_valid = (fill == 3'd4);

endmodule

// File: tb/tb_hdb3_decoder.sv
// Bench for hdb3_decoder. A symbol-history reference model recomputes the
// decoded bits and error flags from the HDB3 rules, and every scenario task
// compares the DUT's outputs against it each cycle.
module tb_hdb3_decoder;
  localparam int ERR_W = 4;
  localparam int CMAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       hdb3_in = 2'b00;
  logic             err_clr = 1'b0;
  logic             data_out, data_valid, code_err, v_err, zero_err;
  logic [ERR_W-1:0] err_cnt;

  hdb3_decoder #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .hdb3_in(hdb3_in), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .code_err(code_err),
    .v_err(v_err), .zero_err(zero_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  wire [8:0] obs = {data_valid, data_out, code_err, v_err, zero_err, err_cnt};

  int ncmp = 0;
  int nerr = 0;

  // Reference model. Symbols are encoded as 0, +1, -1 and 2 (illegal).
  int syms[$];
  int bits[$];
  int zr, lpol, lvpol, hv, cnt;
  bit e_code, e_v, e_zero, e_dout, e_dv;
  logic [8:0] expv;

  function automatic logic [1:0] enc(int s);
    case (s)
      1:       return 2'b01;
      -1:      return 2'b11;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit is_mk(int s);
    return (s == 1) || (s == -1);
  endfunction

  task automatic model_clear();
    syms.delete(); bits.delete();
    zr = 0; lpol = 0; lvpol = 0; hv = 0; cnt = 0;
    e_code = 0; e_v = 0; e_zero = 0; e_dout = 0; e_dv = 0;
    expv = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hdb3_in = 2'b00; err_clr = 1'b0;
    #2;
    model_clear();
    rst = 1'b0;
  endtask

  // Drive one symbol, clock it in, then advance the model.
  task automatic step(input int s, input bit clr);
    int n;
    hdb3_in = enc(s);
    err_clr = clr;
    @(posedge clk);
    #1;
    if (clr) cnt = 0;
    else if ((e_code || e_v || e_zero) && cnt < CMAX) cnt++;
    n = syms.size();
    e_code = 0; e_v = 0; e_zero = 0;
    if (s == 0) begin
      bits.push_back(0);
      if (zr < 7) zr++;
      if (zr == 4) e_zero = 1;
    end else if (s == 2) begin
      bits.push_back(0);
      e_code = 1;
    end else if (lpol == 0 || s != lpol) begin
      bits.push_back(1);
      lpol = s; zr = 0;
    end else begin
      bits.push_back(0);
      for (int d = 1; d <= 3; d++) if (n - d >= 0) bits[n-d] = 0;
      if ((n >= 1 && is_mk(syms[n-1])) || (n >= 2 && is_mk(syms[n-2]))) e_v = 1;
      if (hv && s == lvpol) e_v = 1;
      lvpol = s; hv = 1; lpol = s; zr = 0;
    end
    syms.push_back(s);
    e_dv   = (n >= 3);
    e_dout = (n >= 3) ? bits[n-3][0] : 1'b0;
    expv = {e_dv, e_dout, e_code, e_v, e_zero, cnt[ERR_W-1:0]};
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_clear();
    ncmp++;
    if (obs !== 9'd0) begin nerr++; $display("FAIL reset_async: got %b expected %b", obs, 9'd0); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL reset_fill[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_000v();
    int seq[12] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL 000v[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_b00v();
    int seq[13] = '{1, -1, 1, 0, 0, 1, -1, 0, 0, -1, 0, 0, 0};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL b00v[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_illegal();
    int seq[8] = '{1, 2, -1, 0, 1, 0, 0, 0};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], (i == 3));
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL illegal[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_bad_v();
    int seq[14] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i], 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL bad_v[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(2, 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL sat[%0d]: got %b expected %b", i, obs, expv); end
    end
    step(2, 0);
    ncmp++;
    if (err_cnt !== 4'(CMAX)) begin nerr++; $display("FAIL sat_hold: got %0d expected %0d", err_cnt, CMAX); end
    step(2, 1);
    ncmp++;
    if (obs !== expv || err_cnt !== '0) begin nerr++; $display("FAIL clr_with_err: got %b expected %b", obs, expv); end
  endtask

  task automatic test_random();
    int r, s;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      s = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? -1 : 2;
      step(s, ($urandom_range(0, 15) == 0));
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL random[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  task automatic test_reset_midstream();
    int seq[10] = '{1, -1, 0, 1, 0, 0, 1, -1, 1, -1};
    do_reset();
    foreach (seq[i]) step(seq[i], 0);
    ncmp++;
    if (data_valid !== 1'b1) begin nerr++; $display("FAIL mid_pre_valid: got %b expected 1", data_valid); end
    #2 rst = 1'b1;
    #1;
    model_clear();
    ncmp++;
    if (obs !== 9'd0) begin nerr++; $display("FAIL mid_async: got %b expected %b", obs, 9'd0); end
    #2 rst = 1'b0;
    step(-1, 0);
    ncmp++;
    if (obs !== expv) begin nerr++; $display("FAIL mid_first: got %b expected %b", obs, expv); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      ncmp++;
      if (obs !== expv) begin nerr++; $display("FAIL mid_after[%0d]: got %b expected %b", i, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_000v();
    test_b00v();
    test_illegal();
    test_bad_v();
    test_saturation();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
